// File: rtl/bus_responder_pkg.sv
// Shared types and constants for the bus responder slice.
// State encoding and wait-state limits used by the FSM and its bus interface.
package bus_responder_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_DONE,
    S_RECOVER
  } state_t;

  localparam int unsigned WAIT_MAX = 15;

  // Counter preload for a given wait count, clamped to the legal range
  function automatic logic [3:0] wait_load(int unsigned n);
    int unsigned c;
    c = (n > WAIT_MAX) ? WAIT_MAX : n;
    return (c == 0) ? 4'd0 : 4'(c - 1);
  endfunction

endpackage

// File: rtl/bus_responder_if.sv
// Initiator/responder bus bundle for the word responder.
// The master drives the request; the slave returns data and status.
interface bus_responder_if;

  logic [31:0] addr;
  logic [31:0] wdata;
  logic        r;
  logic [3:0]  w;
  logic [31:0] rdata;
  logic        ready;
  logic        busy;

  modport master (
    output addr, wdata, r, w,
    input  rdata, ready, busy
  );

  modport slave (
    input  addr, wdata, r, w,
    output rdata, ready, busy
  );

endinterface

// File: rtl/bus_responder_ram.sv
// Word storage with per-byte write enables and a combinational read.
// Contents are never reset.
module bus_word_ram #(
  parameter int unsigned DEPTH_LOG2 = 6
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [3:0]            be,
  input  logic [DEPTH_LOG2-1:0] idx,
  input  logic [31:0]           wdata,
  output logic [31:0]           rdata
);

  logic [31:0] mem [2**DEPTH_LOG2];

  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem[idx][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

  assign rdata = mem[idx];

endmodule

// File: rtl/bus_responder.sv
// Wait-stated single-word bus responder over a decoded address window.
// One request at a time; a held request is serviced once.
module bus_responder
  import bus_responder_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int unsigned DEPTH_LOG2  = 6,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input logic            clk,
  input logic            rst,
  bus_responder_if.slave bus
);

  localparam bit         HAS_WAIT = WAIT_CYCLES != 0;
  localparam logic [3:0] LOAD     = wait_load(WAIT_CYCLES);

  state_t      state, state_n;
  logic [3:0]  cnt, cnt_n;
  logic        take;

  logic [29:0] lat_addr;
  logic [31:0] lat_wdata;
  logic        lat_r;
  logic [3:0]  lat_w;
  logic        err;

  logic [29:0]           woff;
  logic [DEPTH_LOG2-1:0] idx;
  logic                  hit;
  logic                  is_wr;
  logic                  conflict;
  logic                  we;
  logic [31:0]           ram_q;
  logic                  unused;

  // Decode on word offsets; the byte lane bits never matter
  assign woff     = lat_addr - BASE_ADDR[31:2];
  assign hit      = (woff >> DEPTH_LOG2) == '0;
  assign idx      = woff[DEPTH_LOG2-1:0];
  assign conflict = lat_r && (lat_w != '0);
  assign is_wr    = !lat_r && (lat_w != '0);
  assign we       = (state == S_DONE) && !rst && hit && is_wr;
  assign unused   = ^{bus.addr[1:0], err};

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    take    = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (bus.r || (bus.w != '0)) begin
          take = 1'b1;
          if (HAS_WAIT) begin
            state_n = S_WAIT;
            cnt_n   = LOAD;
          end else begin
            state_n = S_DONE;
          end
        end
      end
      S_WAIT: begin
        if (cnt == '0) state_n = S_DONE;
        else           cnt_n   = cnt - 4'd1;
      end
      S_DONE: begin
        state_n = S_RECOVER;
      end
      S_RECOVER: begin
        if (!bus.r && (bus.w == '0)) state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      cnt       <= '0;
      lat_addr  <= '0;
      lat_wdata <= '0;
      lat_r     <= 1'b0;
      lat_w     <= '0;
      err       <= 1'b0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      if (take) begin
        lat_addr  <= bus.addr[31:2];
        lat_wdata <= bus.wdata;
        lat_r     <= bus.r;
        lat_w     <= bus.w;
      end
      if ((state == S_DONE) && (!hit || conflict)) err <= 1'b1;
    end
  end

  bus_word_ram #(
    .DEPTH_LOG2(DEPTH_LOG2)
  ) u_ram (
    .clk   (clk),
    .we    (we),
    .be    (lat_w),
    .idx   (idx),
    .wdata (lat_wdata),
    .rdata (ram_q)
  );

  assign bus.ready = state == S_DONE;
  assign bus.busy  = state != S_IDLE;
  assign bus.rdata = ((state == S_DONE) && hit) ? ram_q : '0;

endmodule

// File: tb/tb_bus_responder.sv
// Scoreboard bench for bus_responder: a 2-wait-state and a 0-wait-state build.
// Stimulus pushes expected completions; a negedge monitor pops and compares.
module tb_bus_responder;

  localparam logic [31:0] B = 32'h0000_1000;

  typedef struct {
    logic [31:0] rdata;
    bit          cmp;
    int          edge_no;
    int          lat;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   nchk = 0;
  int   nfail = 0;
  int   rcnt [2];
  exp_t q2 [$];
  exp_t q0 [$];

  bus_responder_if b2 ();
  bus_responder_if b0 ();

  bus_responder #(
    .BASE_ADDR(B), .DEPTH_LOG2(6), .WAIT_CYCLES(2)
  ) dut2 (
    .clk(clk), .rst(rst), .bus(b2)
  );

  bus_responder #(
    .BASE_ADDR(B), .DEPTH_LOG2(6), .WAIT_CYCLES(0)
  ) dut0 (
    .clk(clk), .rst(rst), .bus(b0)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic logic rdy(bit sel);
    return sel ? b0.ready : b2.ready;
  endfunction

  function automatic logic bsy(bit sel);
    return sel ? b0.busy : b2.busy;
  endfunction

  task automatic drive(bit sel, logic [31:0] a, logic [31:0] d,
                       logic rd, logic [3:0] we);
    if (sel) begin
      b0.addr = a; b0.wdata = d; b0.r = rd; b0.w = we;
    end else begin
      b2.addr = a; b2.wdata = d; b2.r = rd; b2.w = we;
    end
  endtask

  task automatic mon(bit sel);
    exp_t        e;
    logic        rd;
    logic [31:0] dat;
    rd  = sel ? b0.ready : b2.ready;
    dat = sel ? b0.rdata : b2.rdata;
    if (rd) begin
      rcnt[sel]++;
      if ((sel ? q0.size() : q2.size()) == 0) begin
        nchk++;
        nfail++;
        $display("FAIL unexpected_ready dut%0d: got ready=1, expected 0", sel);
      end else begin
        e = sel ? q0.pop_front() : q2.pop_front();
        if (e.cmp) chk(sel ? "rdata0" : "rdata2", dat, e.rdata);
        chk(sel ? "latency0" : "latency2", cyc - e.edge_no, e.lat);
      end
    end else begin
      chk(sel ? "rdata_idle0" : "rdata_idle2", dat, 32'h0);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      mon(1'b0);
      mon(1'b1);
    end
  end

  // Caller is #1 after a rising edge; returns #1 after the edge that idles
  task automatic txn(bit sel, logic [31:0] a, logic [31:0] d,
                     logic rd, logic [3:0] we, logic [31:0] exp,
                     bit dc, int hold, output bit hb, output bit ib);
    exp_t e;
    int   n;
    drive(sel, a, d, rd, we);
    e.rdata   = exp;
    e.cmp     = !dc;
    e.edge_no = cyc + 1;
    e.lat     = sel ? 0 : 2;
    if (sel) q0.push_back(e);
    else     q2.push_back(e);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!rdy(sel) && n < 50);
    if (!rdy(sel)) begin
      nchk++;
      nfail++;
      $display("FAIL ready_timeout dut%0d: got no ready, expected ready", sel);
    end
    hb = 1'b1;
    repeat (hold + 1) begin
      @(posedge clk);
      #1;
      hb &= bsy(sel);
    end
    drive(sel, 32'h0, 32'h0, 1'b0, 4'h0);
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (bsy(sel) && n < 50);
    ib = (n == 1) && !bsy(sel);
  endtask

  task automatic wr(bit sel, logic [31:0] a, logic [31:0] d,
                    logic [3:0] we, logic [31:0] exp, bit dc);
    bit hb, ib;
    txn(sel, a, d, 1'b0, we, exp, dc, 0, hb, ib);
  endtask

  task automatic rd(bit sel, logic [31:0] a, logic [31:0] exp);
    bit hb, ib;
    txn(sel, a, 32'h0, 1'b1, 4'h0, exp, 1'b0, 0, hb, ib);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bit hb, ib;
    int c0;
    rcnt[0] = 0;
    rcnt[1] = 0;
    rst = 1'b1;
    drive(1'b0, 32'h0, 32'h0, 1'b0, 4'h0);
    drive(1'b1, 32'h0, 32'h0, 1'b0, 4'h0);
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy2", {31'b0, b2.busy}, 32'h0);
    chk("rst_ready2", {31'b0, b2.ready}, 32'h0);
    chk("rst_rdata2", b2.rdata, 32'h0);
    chk("rst_err2", {31'b0, dut2.err}, 32'h0);
    chk("rst_busy0", {31'b0, b0.busy}, 32'h0);
    chk("rst_err0", {31'b0, dut0.err}, 32'h0);
    rst = 1'b0;

    wr(1'b0, B + 0,  32'h0102_0304, 4'hF, 32'h0, 1'b1);
    wr(1'b0, B + 8,  32'hDEAD_BEEF, 4'hF, 32'h0, 1'b1);
    rd(1'b0, B + 8,  32'hDEAD_BEEF);
    wr(1'b0, B + 12, 32'h1122_3344, 4'hF, 32'h0, 1'b1);
    wr(1'b0, B + 12, 32'hAABB_CCDD, 4'b0101, 32'h1122_3344, 1'b0);
    rd(1'b0, B + 12, 32'h11BB_33DD);
    rd(1'b0, B + 11, 32'hDEAD_BEEF);

    c0 = rcnt[0];
    txn(1'b0, B + 8, 32'h0, 1'b1, 4'h0, 32'hDEAD_BEEF, 1'b0, 10, hb, ib);
    chk("held_pulses", rcnt[0] - c0, 1);
    chk("held_busy", {31'b0, hb}, 32'h1);
    chk("held_idle", {31'b0, ib}, 32'h1);

    chk("err_before_miss", {31'b0, dut2.err}, 32'h0);
    rd(1'b0, B + 256, 32'h0);
    chk("err_after_miss", {31'b0, dut2.err}, 32'h1);
    wr(1'b0, B + 256, 32'h5555_5555, 4'hF, 32'h0, 1'b0);
    rd(1'b0, B + 0,  32'h0102_0304);
    rd(1'b0, B + 8,  32'hDEAD_BEEF);
    rd(1'b0, B + 12, 32'h11BB_33DD);

    c0 = rcnt[0];
    drive(1'b0, B + 8, 32'hCAFE_F00D, 1'b0, 4'hF);
    @(posedge clk);
    #1;
    chk("abort_wait_busy", {31'b0, b2.busy}, 32'h1);
    rst = 1'b1;
    drive(1'b0, 32'h0, 32'h0, 1'b0, 4'h0);
    @(posedge clk);
    #1;
    chk("abort_busy", {31'b0, b2.busy}, 32'h0);
    rst = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk("abort_no_ready", rcnt[0] - c0, 0);
    rd(1'b0, B + 8, 32'hDEAD_BEEF);

    wr(1'b1, B + 20, 32'h0A0B_0C0D, 4'hF, 32'h0, 1'b1);
    rd(1'b1, B + 20, 32'h0A0B_0C0D);
    wr(1'b1, B + 24, 32'hF0E0_D0C0, 4'hF, 32'h0, 1'b1);
    wr(1'b1, B + 20, 32'h7700_0000, 4'b1000, 32'h0A0B_0C0D, 1'b0);
    rd(1'b1, B + 20, 32'h770B_0C0D);
    rd(1'b1, B + 24, 32'hF0E0_D0C0);
    chk("err0_clean", {31'b0, dut0.err}, 32'h0);
    txn(1'b1, B + 24, 32'h1234_5678, 1'b1, 4'hF, 32'hF0E0_D0C0,
        1'b0, 0, hb, ib);
    chk("err0_conflict", {31'b0, dut0.err}, 32'h1);
    rd(1'b1, B + 24, 32'hF0E0_D0C0);

    repeat (3) @(posedge clk);
    #1;
    chk("q2_drained", q2.size(), 0);
    chk("q0_drained", q0.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             nchk, nfail);
    $finish;
  end

endmodule
